// File: rtl/simple_risc_pkg.sv
// Shared types and constants for the Simple RISC Machine datapath and control.
// The fetch FSM states and the HALT opcode live here so that decode and fetch agree on them.
package simple_risc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

  // The opcode sits in the top three bits of every instruction.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 3] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one instruction per pass from a 1-cycle-latency RAM,
// and presents it to the controller over valid/ready. It supports branch redirect and stops on HALT.
module instr_fetch_unit
  import simple_risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               take_redirect;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    mem_rd        = 1'b0;
    take_redirect = redirect && (state_q != INIT);

    case (state_q)
      INIT: begin
        pc_d    = start_pc;
        state_d = FETCH;
      end
      FETCH: begin
        mem_rd     = 1'b1;
        mem_addr_d = pc_q;
        state_d    = WAIT;
      end
      WAIT: begin
        // A redirect here means the returning word belongs to the abandoned path.
        if (!take_redirect) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
        end
        pc_d    = pc_q + ADDR_W'(1);
        state_d = HOLD;
      end
      HOLD: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = is_halt(ir_q) ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // A taken branch overrides whatever the state above decided, including a HALT handoff.
    if (take_redirect) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      state_d    = FETCH;
    end
  end

  // The address is driven straight from the PC while fetching and otherwise holds the last one issued.
  assign mem_addr = mem_rd ? pc_q : mem_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign halted   = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mem_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a cycle table for startup and redirect, hand-written
// corner sequences, and a randomized run checked against a transaction-level model of fetch.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  start_pc;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;

  logic [15:0] mem [256];

  int n_cmp;
  int n_bad;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pc    (start_pc),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  redir_pc;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst_n       = 1'b0;
    ir_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    start_pc    = s;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (ir_valid) break;
      step();
    end
    check(name, 32'(ir_valid), 32'd1);
  endtask

  task automatic wait_rd(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (mem_rd) break;
      step();
    end
    check(name, 32'(mem_rd), 32'd1);
  endtask

  initial begin
    logic [7:0]  m_next;
    logic [15:0] m_word;
    bit          m_halted;
    int          handoffs;

    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    ir_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    start_pc    = 8'h00;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101 + 16'h0010);
    mem[8'h00] = 16'hD105;
    mem[8'h01] = 16'h1234;
    mem[8'h30] = 16'hABCD;
    mem[8'h31] = 16'h5678;

    // Cycle table after reset release, start_pc=0: startup latency, then a redirect in WAIT.
    //            ready redir rpc    rd    addr   valid  ir        pc
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00}; // INIT
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00}; // FETCH 0
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00}; // WAIT
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'hD105, 8'h01}; // HOLD, accepted
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 16'hD105, 8'h01}; // FETCH 1
    vecs[5] = '{1'b1, 1'b1, 8'h30, 1'b0, 8'h01, 1'b0, 16'hD105, 8'h01}; // WAIT + redirect
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 16'hD105, 8'h30}; // FETCH 30, stale dropped
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0, 16'hD105, 8'h30}; // WAIT
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 16'hABCD, 8'h31}; // HOLD
    vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0, 16'hABCD, 8'h31}; // FETCH 31

    do_reset(8'h00);
    for (int r = 0; r < 10; r++) begin
      ir_ready    = vecs[r].ready;
      redirect    = vecs[r].redir;
      redirect_pc = vecs[r].redir_pc;
      check($sformatf("tbl%0d_mem_rd", r),   32'(mem_rd),   32'(vecs[r].e_rd));
      check($sformatf("tbl%0d_mem_addr", r), 32'(mem_addr), 32'(vecs[r].e_addr));
      check($sformatf("tbl%0d_ir_valid", r), 32'(ir_valid), 32'(vecs[r].e_valid));
      check($sformatf("tbl%0d_ir", r),       32'(ir),       32'(vecs[r].e_ir));
      check($sformatf("tbl%0d_pc", r),       32'(pc),       32'(vecs[r].e_pc));
      check($sformatf("tbl%0d_halted", r),   32'(halted),   32'd0);
      step();
    end
    redirect = 1'b0;

    // Stall in HOLD for five cycles, then release.
    ir_ready = 1'b0;
    wait_valid("stall_wait_valid", 8);
    check("stall_ir_first", 32'(ir), 32'h5678);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_ir_valid", 32'(ir_valid), 32'd1);
      check("stall_ir",       32'(ir),       32'h5678);
      check("stall_mem_rd",   32'(mem_rd),   32'd0);
      check("stall_pc",       32'(pc),       32'h32);
    end
    ir_ready = 1'b1;
    step();
    check("stall_resume_rd",    32'(mem_rd),   32'd1);
    check("stall_resume_addr",  32'(mem_addr), 32'h32);
    check("stall_resume_valid", 32'(ir_valid), 32'd0);

    // HALT at address 2: fetch stops until a redirect.
    mem[8'h02] = 16'hE000;
    do_reset(8'h02);
    wait_valid("halt_wait_valid", 8);
    check("halt_ir", 32'(ir), 32'hE000);
    step();
    check("halt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_mem_rd",   32'(mem_rd),   32'd0);
      check("halt_held",     32'(halted),   32'd1);
      check("halt_ir_valid", 32'(ir_valid), 32'd0);
    end
    redirect    = 1'b1;
    redirect_pc = 8'h00;
    step();
    redirect = 1'b0;
    check("halt_exit_halted", 32'(halted),   32'd0);
    check("halt_exit_rd",     32'(mem_rd),   32'd1);
    check("halt_exit_addr",   32'(mem_addr), 32'h00);

    // PC wrap from 8'hFF to 8'h00.
    mem[8'hFF] = 16'h1111;
    do_reset(8'hFF);
    wait_rd("wrap_wait_rd", 8);
    check("wrap_first_addr", 32'(mem_addr), 32'hFF);
    wait_valid("wrap_wait_valid", 8);
    check("wrap_ir", 32'(ir), 32'h1111);
    check("wrap_pc", 32'(pc), 32'h00);
    step();
    check("wrap_next_rd",   32'(mem_rd),   32'd1);
    check("wrap_next_addr", 32'(mem_addr), 32'h00);

    // Asynchronous reset in the middle of WAIT, then restart from a new start_pc.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ir_valid", 32'(ir_valid), 32'd0);
    check("arst_mem_rd",   32'(mem_rd),   32'd0);
    check("arst_halted",   32'(halted),   32'd0);
    check("arst_ir",       32'(ir),       32'h0000);
    check("arst_pc",       32'(pc),       32'h00);
    check("arst_mem_addr", 32'(mem_addr), 32'h00);
    mem[8'h05] = 16'h4455;
    do_reset(8'h05);
    wait_rd("arst_restart_rd", 8);
    check("arst_restart_addr", 32'(mem_addr), 32'h05);
    wait_valid("arst_restart_valid", 8);
    check("arst_restart_ir", 32'(ir), 32'h4455);

    // Randomized run against a transaction-level model: the controller should receive
    // mem[a], mem[a+1], ... starting at start_pc or the latest redirect target.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    m_next   = 8'($urandom);
    m_halted = 1'b0;
    handoffs = 0;
    do_reset(m_next);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_halted) begin
        check("rnd_halted",      32'(halted),   32'd1);
        check("rnd_halt_rd",     32'(mem_rd),   32'd0);
        check("rnd_halt_valid",  32'(ir_valid), 32'd0);
      end else begin
        check("rnd_not_halted", 32'(halted), 32'd0);
        if (ir_valid) check("rnd_ir",   32'(ir),       32'(mem[m_next]));
        if (mem_rd)   check("rnd_addr", 32'(mem_addr), 32'(m_next));
      end
      ir_ready    = ($urandom_range(0, 3) != 0);
      redirect    = (cyc > 0) && ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom);
      if (ir_valid && ir_ready) begin
        handoffs++;
        m_word = mem[m_next];
        if (m_word[15:13] == 3'b111 && !redirect) m_halted = 1'b1;
        m_next = m_next + 8'd1;
      end
      if (redirect) begin
        m_next   = redirect_pc;
        m_halted = 1'b0;
      end
      step();
    end
    redirect = 1'b0;
    check("rnd_progress", 32'(handoffs > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
